dcache_ctrl: RTL and testbench

Controller for the direct-mapped data cache between the RISC-V core's load/store port and main data memory. Holds the tag and valid arrays internally and sequences the external cache data array (32 lines x 4 words) and main memory (1024 words) through a req/ack handshake. Policy is write-through, no-write-allocate, with 4-word line refill on read miss. Stalls the core while any access is outstanding, and keeps hit/miss counters for performance checks.

---
 rtl/dcache_ctrl.sv | 169 ++++++++++++++++
 tb/tb_dcache_ctrl.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// rtl/dcache_ctrl.sv - direct-mapped write-through data cache controller
module dcache_ctrl #(
  parameter int ADDR_W   = 10,
  parameter int INDEX_W  = 5,
  parameter int OFFSET_W = 2,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                cpu_rd,
  input  logic                cpu_wr,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [31:0]         cpu_wdata,
  output logic [31:0]         cpu_rdata,
  output logic                cpu_stall,
  output logic [INDEX_W-1:0]  cache_idx,
  output logic [OFFSET_W-1:0] cache_off,
  output logic                cache_we,
  output logic [31:0]         cache_wdata,
  input  logic [31:0]         cache_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  input  logic [31:0]         mem_rdata,
  input  logic                mem_ack,
  output logic [CNT_W-1:0]    hit_cnt,
  output logic [CNT_W-1:0]    miss_cnt
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE_MEM} state_t;

  state_t              state;
  logic [TAG_W-1:0]    tag_arr [LINES];
  logic [LINES-1:0]    valid;
  logic [TAG_W-1:0]    r_tag;
  logic [INDEX_W-1:0]  r_idx;
  logic [OFFSET_W-1:0] count;
  logic [OFFSET_W-1:0] count_nxt;
  // Marks the IDLE cycle right after a refill so the replayed read is not counted twice.
  logic                refilled;

  logic [TAG_W-1:0]    a_tag;
  logic [INDEX_W-1:0]  a_idx;
  logic [OFFSET_W-1:0] a_off;
  logic                hit;

  assign a_tag     = cpu_addr[ADDR_W-1 -: TAG_W];
  assign a_idx     = cpu_addr[OFFSET_W +: INDEX_W];
  assign a_off     = cpu_addr[OFFSET_W-1:0];
  assign hit       = valid[a_idx] && (tag_arr[a_idx] == a_tag);
  assign count_nxt = count + OFFSET_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  // Controller FSM: tag/valid arrays, counters and the registered memory handshake.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      valid     <= '0;
      for (int i = 0; i < LINES; i++) tag_arr[i] <= '0;
      r_tag     <= '0;
      r_idx     <= '0;
      count     <= '0;
      refilled  <= 1'b0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      refilled <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_wr) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            if (hit) hit_cnt  <= sat_inc(hit_cnt);
            else     miss_cnt <= sat_inc(miss_cnt);
            state     <= WRITE_MEM;
          end else if (cpu_rd) begin
            if (hit) begin
              if (!refilled) hit_cnt <= sat_inc(hit_cnt);
            end else begin
              r_tag    <= a_tag;
              r_idx    <= a_idx;
              count    <= '0;
              mem_req  <= 1'b1;
              mem_we   <= 1'b0;
              mem_addr <= {a_tag, a_idx, {OFFSET_W{1'b0}}};
              miss_cnt <= sat_inc(miss_cnt);
              state    <= REFILL;
            end
          end
        end
        REFILL: begin
          if (mem_ack) begin
            count    <= count_nxt;
            mem_addr <= {r_tag, r_idx, count_nxt};
            if (&count) begin
              tag_arr[r_idx] <= r_tag;
              valid[r_idx]   <= 1'b1;
              mem_req        <= 1'b0;
              mem_addr       <= '0;
              refilled       <= 1'b1;
              state          <= IDLE;
            end
          end
        end
        WRITE_MEM: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Core-facing and data-array outputs; held quiet while reset is asserted.
  always_comb begin
    cpu_stall   = 1'b0;
    cpu_rdata   = '0;
    cache_idx   = a_idx;
    cache_off   = a_off;
    cache_we    = 1'b0;
    cache_wdata = '0;
    if (rstn) begin
      case (state)
        IDLE: begin
          if (cpu_wr) begin
            cpu_stall   = 1'b1;
            cache_we    = hit;
            cache_wdata = cpu_wdata;
          end else if (cpu_rd) begin
            if (hit) cpu_rdata = cache_rdata;
            else     cpu_stall = 1'b1;
          end
        end
        REFILL: begin
          cpu_stall   = 1'b1;
          cache_idx   = r_idx;
          cache_off   = count;
          cache_we    = mem_ack;
          cache_wdata = mem_rdata;
        end
        WRITE_MEM: begin
          cpu_stall = ~mem_ack;
          cache_idx = mem_addr[OFFSET_W +: INDEX_W];
          cache_off = mem_addr[OFFSET_W-1:0];
        end
        default: cpu_stall = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// tb/tb_dcache_ctrl.sv - scoreboard bench for dcache_ctrl
module tb_dcache_ctrl;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cpu_rd = 1'b0;
  logic        cpu_wr = 1'b0;
  logic [9:0]  cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [4:0]  cache_idx;
  logic [1:0]  cache_off;
  logic        cache_we;
  logic [31:0] cache_wdata;
  logic [31:0] cache_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  always #5 clk = ~clk;

  dcache_ctrl #(.ADDR_W(10), .INDEX_W(5), .OFFSET_W(2), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .cache_idx(cache_idx), .cache_off(cache_off), .cache_we(cache_we),
    .cache_wdata(cache_wdata), .cache_rdata(cache_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  typedef struct packed {logic we; logic [9:0] addr; logic [31:0] data;} mem_txn_t;
  typedef struct packed {logic [4:0] idx; logic [1:0] off; logic [31:0] data;} cw_t;

  int          tests = 0;
  int          fails = 0;
  int          lat = 2;
  int          n_acks = 0;
  int          wait_cnt = 0;
  bit          spur = 1'b0;
  int          hit_exp = 0;
  int          miss_exp = 0;
  logic [31:0] mem_model [1024];
  logic [31:0] golden [1024];
  logic [31:0] cache_arr [32][4];
  mem_txn_t    exp_mem[$];
  cw_t         exp_cw[$];
  mem_txn_t    mem_e;
  cw_t         cw_e;
  logic [9:0]  snap_addr;
  logic [31:0] snap_wdata;
  logic        snap_we;

  assign cache_rdata = cache_arr[cache_idx][cache_off];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_cnt(input string tag);
    check({tag, "_hit_cnt"}, 32'(hit_cnt), 32'(hit_exp));
    check({tag, "_miss_cnt"}, 32'(miss_cnt), 32'(miss_exp));
  endtask

  // Queue the four line-fill reads and data-array writes of the line holding a.
  task automatic expect_refill(input logic [9:0] a);
    logic [9:0] base;
    base = {a[9:2], 2'b00};
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back('{1'b0, base + 10'(i), 32'h0});
      exp_cw.push_back('{base[6:2], 2'(i), golden[base + 10'(i)]});
    end
  endtask

  task automatic do_read(input logic [9:0] a, input logic [31:0] exp, input int exp_stall,
                         input string tag);
    int n;
    n = 0;
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
    @(negedge clk);
    while (cpu_stall && n < 300) begin n++; @(negedge clk); end
    check({tag, "_stall_cycles"}, 32'(n), 32'(exp_stall));
    check({tag, "_rdata"}, cpu_rdata, exp);
    @(posedge clk); #1;
    cpu_rd = 1'b0;
  endtask

  task automatic do_write(input logic [9:0] a, input logic [31:0] d, input bit is_hit,
                          input bit both, input string tag);
    int n;
    n = 0;
    exp_mem.push_back('{1'b1, a, d});
    if (is_hit) exp_cw.push_back('{a[6:2], a[1:0], d});
    golden[a] = d;
    cpu_wr = 1'b1; cpu_rd = both; cpu_addr = a; cpu_wdata = d;
    @(negedge clk);
    while (cpu_stall && n < 300) begin n++; @(negedge clk); end
    check({tag, "_stall_cycles"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_rd = 1'b0;
  endtask

  // Main memory responder: acks after lat cycles, checks stability and the expected transaction.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (!rstn) begin
        wait_cnt = 0;
      end else if (mem_req) begin
        if (wait_cnt == 0) begin
          snap_addr = mem_addr; snap_wdata = mem_wdata; snap_we = mem_we;
        end else begin
          check("mem_addr_stable", 32'(mem_addr), 32'(snap_addr));
          check("mem_wdata_stable", mem_wdata, snap_wdata);
          check("mem_we_stable", 32'(mem_we), 32'(snap_we));
        end
        wait_cnt++;
        if (wait_cnt >= lat) begin
          mem_ack = 1'b1;
          n_acks++;
          wait_cnt = 0;
          if (exp_mem.size() == 0) begin
            check("mem_req_unexpected", 32'(mem_req), 32'd0);
          end else begin
            mem_e = exp_mem.pop_front();
            check("mem_we", 32'(mem_we), 32'(mem_e.we));
            check("mem_addr", 32'(mem_addr), 32'(mem_e.addr));
            if (mem_e.we) check("mem_wdata", mem_wdata, mem_e.data);
          end
          if (mem_we) mem_model[mem_addr] = mem_wdata;
          else        mem_rdata = mem_model[mem_addr];
        end
      end else begin
        wait_cnt = 0;
        if (spur) begin
          mem_ack = 1'b1;
          mem_rdata = 32'h1234_5678;
          spur = 1'b0;
        end
      end
    end
  end

  // External data array: checks each write against the queue, then stores it.
  initial begin
    forever begin
      @(negedge clk);
      if (rstn && cache_we) begin
        if (exp_cw.size() == 0) begin
          check("cache_we_unexpected", 32'(cache_we), 32'd0);
        end else begin
          cw_e = exp_cw.pop_front();
          check("cache_idx", 32'(cache_idx), 32'(cw_e.idx));
          check("cache_off", 32'(cache_off), 32'(cw_e.off));
          check("cache_wdata", cache_wdata, cw_e.data);
        end
        cache_arr[cache_idx][cache_off] = cache_wdata;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem_model[i] = 32'h5A00_0000 + 32'(i) * 32'h0001_0003;
      golden[i]    = mem_model[i];
    end
    for (int i = 0; i < 32; i++)
      for (int j = 0; j < 4; j++) cache_arr[i][j] = '0;

    // Reset state
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_cache_we", 32'(cache_we), 32'd0);
    check("rst_stall", 32'(cpu_stall), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    check("rst_cache_wdata", cache_wdata, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check_cnt("rst");
    @(negedge clk); rstn = 1'b1;
    @(posedge clk); #1;

    // 1: read miss with line refill, latency 2
    lat = 2;
    expect_refill(10'h005);
    miss_exp++;
    do_read(10'h005, golden[10'h005], 1 + 4 * lat, "t1_read_miss");
    check_cnt("t1");

    // 2: read hit, no stall
    hit_exp++;
    do_read(10'h006, golden[10'h006], 0, "t2_read_hit");
    check("t2_no_mem_req", 32'(mem_req), 32'd0);
    check_cnt("t2");

    // 3: write hit then read back
    hit_exp++;
    do_write(10'h007, 32'hDEAD_BEEF, 1'b1, 1'b0, "t3_write_hit");
    check_cnt("t3w");
    hit_exp++;
    do_read(10'h007, 32'hDEAD_BEEF, 0, "t3_read_back");
    check_cnt("t3r");

    // 4: write miss (no allocate), conflicting refill, eviction
    miss_exp++;
    do_write(10'h105, 32'hCAFE_F00D, 1'b0, 1'b0, "t4_write_miss");
    check_cnt("t4w");
    expect_refill(10'h105);
    miss_exp++;
    do_read(10'h105, 32'hCAFE_F00D, 1 + 4 * lat, "t4_read_105");
    check_cnt("t4r1");
    expect_refill(10'h005);
    miss_exp++;
    do_read(10'h005, golden[10'h005], 1 + 4 * lat, "t4_read_evicted");
    check_cnt("t4r2");

    // 5: reset after second refill ack
    begin
      int base_acks;
      int n;
      base_acks = n_acks;
      n = 0;
      expect_refill(10'h040);
      cpu_rd = 1'b1; cpu_addr = 10'h040;
      while (n_acks < base_acks + 2 && n < 300) begin @(negedge clk); n++; end
      check("t5_two_acks", 32'(n_acks - base_acks), 32'd2);
      @(posedge clk); #2;
      rstn = 1'b0;
      #1;
      hit_exp = 0; miss_exp = 0;
      check("t5_mem_req", 32'(mem_req), 32'd0);
      check("t5_stall", 32'(cpu_stall), 32'd0);
      check_cnt("t5_rst");
      exp_mem.delete();
      exp_cw.delete();
      cpu_rd = 1'b0;
      @(negedge clk); rstn = 1'b1;
      @(posedge clk); #1;
      expect_refill(10'h040);
      miss_exp++;
      do_read(10'h040, golden[10'h040], 1 + 4 * lat, "t5_reread");
      check_cnt("t5");
    end

    // 6: slow ack on a combined rd+wr, then spurious ack in IDLE
    lat = 6;
    hit_exp++;
    do_write(10'h041, 32'h0BAD_F00D, 1'b1, 1'b1, "t6_write_both");
    check_cnt("t6w");
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("t6_spur_mem_req", 32'(mem_req), 32'd0);
    check("t6_spur_stall", 32'(cpu_stall), 32'd0);
    check_cnt("t6_spur");
    hit_exp++;
    do_read(10'h041, 32'h0BAD_F00D, 0, "t6_read_back");
    hit_exp++;
    do_read(10'h040, golden[10'h040], 0, "t6_read_neighbor");
    check_cnt("t6");

    repeat (2) @(posedge clk);
    #1;
    check("mem_queue_left", 32'(exp_mem.size()), 32'd0);
    check("cw_queue_left", 32'(exp_cw.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
